image_frame_buffer: RTL and testbench

- Parametrised, multi-bank successor to the single-frame image buffer.
- Packs a stream of IN_WIDTH-bit beats from the UART/SPI byte receiver into IMG_WIDTH*IMG_HEIGHT-bit binarised frames.
- Holds up to NUM_BANKS complete frames, so the host can stream frame N+1 while the BNN consumes frame N.
- Sits between the byte receiver (valid/ready write side) and the BNN inference controller (frame_valid/frame_ack read side).

---
 rtl/image_frame_buffer_pkg.sv | 14 +
 rtl/image_frame_buffer_bank.sv | 26 ++
 rtl/image_frame_buffer.sv | 96 +++++++++
 tb/tb_image_frame_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_frame_buffer_pkg.sv
// img_buf_pkg: default frame geometry and beat-count helpers shared by the frame buffer files
package img_buf_pkg;
  localparam int DEF_IMG_WIDTH  = 30;
  localparam int DEF_IMG_HEIGHT = 30;
  localparam int DEF_IN_WIDTH   = 8;
  localparam int DEF_IMG_BITS   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  typedef logic [DEF_IMG_BITS-1:0] img_t;
  function automatic int calc_beats(input int img_bits, input int in_width);
    return (img_bits + in_width - 1) / in_width;
  endfunction
  function automatic int calc_last_bits(input int img_bits, input int in_width);
    return img_bits - (calc_beats(img_bits, in_width) - 1) * in_width;
  endfunction
endpackage

// File: rtl/image_frame_buffer_bank.sv
// image_bank: one frame of storage written a beat at a time, read full width
module image_bank #(
  parameter int IMG_BITS  = 900,
  parameter int IN_WIDTH  = 8,
  parameter int BEATS     = 113,
  parameter int LAST_BITS = 4,
  parameter int BEAT_W    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [BEAT_W-1:0]   beat_idx,
  input  logic [IN_WIDTH-1:0] data,
  output logic [IMG_BITS-1:0] q
);
  // each beat owns its own slice; the final slice is narrower and keeps only the low data bits
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    localparam int W = (b == BEATS - 1) ? LAST_BITS : IN_WIDTH;
    logic [W-1:0] seg_q, seg_d;
    always_comb seg_d = (we && beat_idx == BEAT_W'(b)) ? data[W-1:0] : seg_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) seg_q <= '0;
      else seg_q <= seg_d;
    assign q[b*IN_WIDTH +: W] = seg_q;
  end
endmodule

// File: rtl/image_frame_buffer.sv
// image_frame_buffer: packs input beats into binarised frames held in a ring of frame banks
module image_frame_buffer
  import img_buf_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int NUM_BANKS  = 2,
  localparam int IMG_BITS  = IMG_WIDTH * IMG_HEIGHT,
  localparam int BEATS     = calc_beats(IMG_BITS, IN_WIDTH),
  localparam int LAST_BITS = calc_last_bits(IMG_BITS, IN_WIDTH),
  localparam int BEAT_W    = $clog2(BEATS + 1),
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [IN_WIDTH-1:0] wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic                frame_valid,
  output logic [IMG_BITS-1:0] frame_out,
  input  logic                frame_ack,
  output logic [BANK_W:0]     frames_stored,
  output logic [BEAT_W-1:0]   beat_count,
  output logic                overflow
);
  // flag/mux arrays are padded to a power of two so bank pointers index them at full width
  localparam int NB_P2 = 1 << BANK_W;
  logic [NB_P2-1:0]    full_q, full_d;
  logic [BANK_W-1:0]   wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                ovf_q, ovf_d;
  logic [IMG_BITS-1:0] bank_q [NB_P2];
  logic                accept, ack, last;
  function automatic logic [BANK_W-1:0] nxt(input logic [BANK_W-1:0] p);
    return (p == BANK_W'(NUM_BANKS - 1)) ? '0 : p + BANK_W'(1);
  endfunction
  for (genvar i = 0; i < NB_P2; i++) begin : g_bank
    if (i < NUM_BANKS) begin : g_real
      image_bank #(
        .IMG_BITS(IMG_BITS), .IN_WIDTH(IN_WIDTH), .BEATS(BEATS),
        .LAST_BITS(LAST_BITS), .BEAT_W(BEAT_W)
      ) u_bank (
        .clk(clk), .rst_n(rst_n),
        .we(accept && wr_bank_q == BANK_W'(i)),
        .beat_idx(beat_q), .data(wr_data), .q(bank_q[i])
      );
    end else begin : g_none
      assign bank_q[i] = '0;
    end
  end
  assign wr_ready    = !full_q[wr_bank_q] && !clear;
  assign frame_valid = full_q[rd_bank_q];
  assign frame_out   = bank_q[rd_bank_q];
  assign beat_count  = beat_q;
  assign overflow    = ovf_q;
  assign accept      = wr_valid && wr_ready;
  assign ack         = frame_ack && frame_valid;
  assign last        = beat_q == BEAT_W'(BEATS - 1);
  always_comb begin
    frames_stored = '0;
    for (int n = 0; n < NB_P2; n++) frames_stored += (BANK_W+1)'(full_q[n]);
  end
  // a writing bank is never full and an acked bank always is, so set and clear never collide
  always_comb begin
    full_d    = full_q;
    wr_bank_d = (accept && last) ? nxt(wr_bank_q) : wr_bank_q;
    rd_bank_d = ack ? nxt(rd_bank_q) : rd_bank_q;
    beat_d    = accept ? (last ? '0 : beat_q + BEAT_W'(1)) : beat_q;
    ovf_d     = ovf_q || (wr_valid && !wr_ready);
    if (accept && last) full_d[wr_bank_q] = 1'b1;
    if (ack) full_d[rd_bank_q] = 1'b0;
    if (clear) begin
      full_d    = '0;
      wr_bank_d = '0;
      rd_bank_d = '0;
      beat_d    = '0;
      ovf_d     = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      beat_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      beat_q    <= beat_d;
      ovf_q     <= ovf_d;
    end
endmodule

// File: tb/tb_image_frame_buffer.sv
// tb_image_frame_buffer: directed stimulus checked against a frame-queue model and literal expectations
module tb_image_frame_buffer;
  import img_buf_pkg::*;
  localparam int IB = 900;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic clear, wr_valid, frame_ack, wr_ready, frame_valid, overflow;
  logic [7:0] wr_data;
  img_t frame_out;
  logic [1:0] frames_stored;
  logic [6:0] beat_count;
  logic c2, v2, a2, r2, fv2, o2;
  logic [15:0] d2;
  img_t fo2, e2;
  logic [1:0] fs2;
  logic [5:0] bc2;
  int n_chk = 0, n_pass = 0;
  image_frame_buffer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .frame_valid(frame_valid), .frame_out(frame_out), .frame_ack(frame_ack),
    .frames_stored(frames_stored), .beat_count(beat_count), .overflow(overflow)
  );
  image_frame_buffer #(.IN_WIDTH(16), .NUM_BANKS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(c2), .wr_data(d2), .wr_valid(v2),
    .wr_ready(r2), .frame_valid(fv2), .frame_out(fo2), .frame_ack(a2),
    .frames_stored(fs2), .beat_count(bc2), .overflow(o2)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask
  task automatic chk_frame(input string nm, input img_t a, input img_t e);
    int fd;
    n_chk++;
    if (a === e) n_pass++;
    else begin
      fd = 0;
      for (int i = IB - 1; i >= 0; i--) if (a[i] !== e[i]) fd = i;
      $display("FAIL %s: first bad bit %0d got %b expected %b, low bits got %h expected %h at %0t",
               nm, fd, a[fd], e[fd], a[63:0], e[63:0], $time);
    end
  endtask
  function automatic logic [7:0] pat(input int m, input int k);
    return m == 0 ? 8'(k) : m == 1 ? 8'hFF : m == 2 ? 8'h00 :
           m == 3 ? 8'(k) ^ 8'hA5 : m == 4 ? 8'(k * 3 + 1) : 8'h3C;
  endfunction
  function automatic img_t build(input int m);
    img_t e;
    logic [7:0] b;
    e = '0;
    for (int k = 0; k < 113; k++) begin
      b = pat(m, k);
      if (k == 112) e[899:896] = b[3:0];
      else e[k*8 +: 8] = b;
    end
    return e;
  endfunction
  // model: queue of completed frames, oldest first, plus the frame being assembled
  img_t m_q[$];
  img_t m_cur;
  int m_beats = 0;
  bit m_ovf = 0;
  bit rdy, ackd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_beats = 0;
      m_ovf = 0;
    end else if (clear) begin
      m_q.delete();
      m_beats = 0;
      m_ovf = 0;
    end else begin
      rdy = m_q.size() < 2;
      ackd = frame_ack && m_q.size() > 0;
      if (wr_valid && !rdy) m_ovf = 1;
      if (ackd) void'(m_q.pop_front());
      if (wr_valid && rdy) begin
        if (m_beats == 112) m_cur[899:896] = wr_data[3:0];
        else m_cur[m_beats*8 +: 8] = wr_data;
        m_beats++;
        if (m_beats == 113) begin
          m_q.push_back(m_cur);
          m_beats = 0;
        end
      end
    end
  end
  always @(negedge clk) if (rst_n) begin
    chk("wr_ready", 32'(wr_ready), 32'((m_q.size() < 2) && !clear));
    chk("frame_valid", 32'(frame_valid), 32'(m_q.size() > 0));
    chk("frames_stored", 32'(frames_stored), m_q.size());
    chk("beat_count", 32'(beat_count), m_beats);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() > 0) chk_frame("frame_out", frame_out, m_q[0]);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    wr_data = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask
  task automatic send_frame(input int m);
    for (int k = 0; k < 113; k++) send(pat(m, k));
  endtask
  task automatic ack1();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    clear = 0; wr_valid = 0; wr_data = 0; frame_ack = 0;
    c2 = 0; v2 = 0; a2 = 0; d2 = 0;
    tick();
    tick();
    chk("rst frame_valid", 32'(frame_valid), 0);
    chk_frame("rst frame_out", frame_out, '0);
    chk("rst frames_stored", 32'(frames_stored), 0);
    chk("rst beat_count", 32'(beat_count), 0);
    chk("rst overflow", 32'(overflow), 0);
    chk("rst dut2 frame_valid", 32'(fv2), 0);
    rst_n = 1'b1;
    tick();
    chk("rst wr_ready", 32'(wr_ready), 1);
    chk("rst dut2 wr_ready", 32'(r2), 1);
    // streaming one frame with a counting pattern
    for (int k = 0; k < 113; k++) send(8'(k));
    chk("t1 frame_valid", 32'(frame_valid), 1);
    chk("t1 out[7:0]", 32'(frame_out[7:0]), 32'h00);
    chk("t1 out[15:8]", 32'(frame_out[15:8]), 32'h01);
    chk("t1 out[895:888]", 32'(frame_out[895:888]), 32'h6F);
    chk("t1 out[899:896]", 32'(frame_out[899:896]), 32'h0);
    chk("t1 frames_stored", 32'(frames_stored), 1);
    chk("t1 beat_count", 32'(beat_count), 0);
    ack1();
    chk("t1 after ack valid", 32'(frame_valid), 0);
    // single bank, 16-bit beats, ack and write together
    e2 = '0;
    for (int k = 0; k < 56; k++) e2[k*16 +: 16] = 16'h1000 + 16'(k);
    e2[899:896] = 4'h8;
    for (int k = 0; k < 57; k++) begin
      d2 = 16'h1000 + 16'(k);
      v2 = 1'b1;
      tick();
      v2 = 1'b0;
    end
    chk("t4 wr_ready", 32'(r2), 0);
    chk("t4 frame_valid", 32'(fv2), 1);
    chk("t4 frames_stored", 32'(fs2), 1);
    chk("t4 beat_count", 32'(bc2), 0);
    chk("t4 out[15:0]", 32'(fo2[15:0]), 32'h1000);
    chk_frame("t4 frame_out", fo2, e2);
    a2 = 1'b1; v2 = 1'b1; d2 = 16'hBEEF;
    tick();
    a2 = 1'b0; v2 = 1'b0;
    chk("t4 no beat taken", 32'(bc2), 0);
    chk("t4 wr_ready back", 32'(r2), 1);
    chk("t4 frame_valid gone", 32'(fv2), 0);
    chk("t4 frames_stored", 32'(fs2), 0);
    chk("t4 overflow", 32'(o2), 1);
    // both banks full, overflow, then ack switches frames
    send_frame(1);
    chk("t2 A valid", 32'(frame_valid), 1);
    send_frame(2);
    chk("t2 frames_stored", 32'(frames_stored), 2);
    chk("t2 wr_ready", 32'(wr_ready), 0);
    chk_frame("t2 frame A", frame_out, {IB{1'b1}});
    send(8'h55);
    chk("t2 overflow", 32'(overflow), 1);
    chk("t2 beat_count", 32'(beat_count), 0);
    ack1();
    chk_frame("t2 frame B", frame_out, '0);
    chk("t2 frame_valid", 32'(frame_valid), 1);
    chk("t2 wr_ready", 32'(wr_ready), 1);
    chk("t2 frames_stored", 32'(frames_stored), 1);
    // last beat of a new frame together with ack of the held one
    for (int k = 0; k < 112; k++) send(pat(3, k));
    wr_data = pat(3, 112); wr_valid = 1'b1; frame_ack = 1'b1;
    tick();
    wr_valid = 1'b0; frame_ack = 1'b0;
    chk("t3 frame_valid", 32'(frame_valid), 1);
    chk("t3 frames_stored", 32'(frames_stored), 1);
    chk("t3 beat_count", 32'(beat_count), 0);
    chk_frame("t3 frame C", frame_out, build(3));
    ack1();
    chk("t3 drained", 32'(frames_stored), 0);
    // clear mid-frame with a beat offered
    for (int k = 0; k < 50; k++) send(8'hC3);
    chk("t5 beat_count 50", 32'(beat_count), 50);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
    #1;
    chk("t5 wr_ready in clear", 32'(wr_ready), 0);
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    chk("t5 beat_count", 32'(beat_count), 0);
    chk("t5 frame_valid", 32'(frame_valid), 0);
    chk("t5 overflow", 32'(overflow), 0);
    send_frame(4);
    chk("t5 frame_valid", 32'(frame_valid), 1);
    chk_frame("t5 frame", frame_out, build(4));
    // asynchronous reset with two full banks
    send_frame(5);
    send(8'h11);
    chk("t6 stored", 32'(frames_stored), 2);
    chk("t6 overflow", 32'(overflow), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6 frame_valid", 32'(frame_valid), 0);
    chk_frame("t6 frame_out", frame_out, '0);
    chk("t6 frames_stored", 32'(frames_stored), 0);
    chk("t6 beat_count", 32'(beat_count), 0);
    chk("t6 overflow", 32'(overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6 wr_ready", 32'(wr_ready), 1);
    chk("t6 frame_valid after", 32'(frame_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
